// File: rtl/tb_doutb_sched_if.sv
// Requester-side handshake bundle for the TB port-B read scheduler.
// Carries the B and B_cache request channels and their burst-complete pulses.
interface tb_doutb_sched_if #(
    parameter int unsigned TB_AW = 10,
    parameter int unsigned LEN_W = 8
);
    logic             b_req_vld;
    logic             b_req_rdy;
    logic [TB_AW-1:0] b_req_addr;
    logic [LEN_W-1:0] b_req_len;
    logic [1:0]       b_req_dir;
    logic             b_done;

    logic             bc_req_vld;
    logic             bc_req_rdy;
    logic [TB_AW-1:0] bc_req_addr;
    logic [LEN_W-1:0] bc_req_len;
    logic [1:0]       bc_req_dir;
    logic             bc_done;

    // Requesters drive the request fields and observe ready/done.
    modport master (
        output b_req_vld, b_req_addr, b_req_len, b_req_dir,
        output bc_req_vld, bc_req_addr, bc_req_len, bc_req_dir,
        input  b_req_rdy, bc_req_rdy, b_done, bc_done
    );

    // The scheduler consumes requests and returns ready/done.
    modport slave (
        input  b_req_vld, b_req_addr, b_req_len, b_req_dir,
        input  bc_req_vld, bc_req_addr, bc_req_len, bc_req_dir,
        output b_req_rdy, bc_req_rdy, b_done, bc_done
    );
endinterface

// File: rtl/tb_doutb_sched.sv
// TB port-B read scheduler: arbitrates B / B_cache burst requests, issues
// consecutive TB reads and tags the returning data with {dest, dir}.
// Optional build macro: TB_SCHED_RR_EN selects round-robin arbitration;
// without it B has fixed priority over B_cache.
module tb_doutb_sched #(
    parameter int unsigned TB_AW  = 10,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    tb_doutb_sched_if.slave   req,
    output logic              TB_enb,
    output logic [TB_AW-1:0]  TB_addrb,
    output logic [2:0]        TB_doutb_sel,
    output logic              busy
);
    localparam int unsigned DCNT_W = 2;
    localparam int unsigned PIPE_W = 4;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t             state;
    state_t             state_d;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_d;
    logic [TB_AW-1:0]   addr_d;
    logic [1:0]         dir;
    logic [1:0]         dir_d;
    logic               dest;
    logic               dest_d;
    logic [DCNT_W-1:0]  dcnt;
    logic [DCNT_W-1:0]  dcnt_d;
    logic               enb_d;
    logic               busy_d;
    logic               done_fire;
    logic               b_done_q;
    logic               bc_done_q;
    logic               b_ok;
    logic               bc_ok;
    logic               grant_b;
    logic               grant_bc;
    logic [PIPE_W-1:0]  pipe [RD_LAT];

`ifdef TB_SCHED_RR_EN
    logic               favor_bc;
`endif

    // Pick the winner among valid non-empty requests; only while idle and out of reset.
    always_comb begin
        b_ok     = req.b_req_vld  && (req.b_req_len  != '0);
        bc_ok    = req.bc_req_vld && (req.bc_req_len != '0);
`ifdef TB_SCHED_RR_EN
        grant_b  = b_ok && (!bc_ok || !favor_bc);
`else
        grant_b  = b_ok;
`endif
        grant_bc = bc_ok && !grant_b;
        if (!sys_rst_n || (state != IDLE)) begin
            grant_b  = 1'b0;
            grant_bc = 1'b0;
        end
    end

    assign req.b_req_rdy  = grant_b;
    assign req.bc_req_rdy = grant_bc;
    assign req.b_done     = b_done_q;
    assign req.bc_done    = bc_done_q;

`ifdef TB_SCHED_RR_EN
    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            favor_bc <= 1'b0;
        end else if (grant_b) begin
            favor_bc <= 1'b1;
        end else if (grant_bc) begin
            favor_bc <= 1'b0;
        end
    end
`endif

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = TB_addrb;
        dir_d   = dir;
        dest_d  = dest;
        dcnt_d  = dcnt;
        enb_d   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_b || grant_bc) begin
                    state_d = BURST;
                    enb_d   = 1'b1;
                    dest_d  = grant_bc;
                    cnt_d   = grant_b ? req.b_req_len  : req.bc_req_len;
                    addr_d  = grant_b ? req.b_req_addr : req.bc_req_addr;
                    dir_d   = grant_b ? req.b_req_dir  : req.bc_req_dir;
                end
            end
            BURST: begin
                addr_d = TB_addrb + TB_AW'(1);
                cnt_d  = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    enb_d = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == DCNT_W'(RD_LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt + DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        done_fire = (state_d == DRAIN) && (dcnt_d == DCNT_W'(RD_LAT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Burst context and registered outputs.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt       <= '0;
            TB_addrb  <= '0;
            dir       <= '0;
            dest      <= 1'b0;
            dcnt      <= '0;
            TB_enb    <= 1'b0;
            busy      <= 1'b0;
            b_done_q  <= 1'b0;
            bc_done_q <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            TB_addrb  <= addr_d;
            dir       <= dir_d;
            dest      <= dest_d;
            dcnt      <= dcnt_d;
            TB_enb    <= enb_d;
            busy      <= busy_d;
            b_done_q  <= done_fire && !dest_d;
            bc_done_q <= done_fire && dest_d;
        end
    end

    // Delay {enb, dest, dir} by the read latency so the tag lines up with read data.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= TB_enb ? {1'b1, dest, dir} : '0;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign TB_doutb_sel = pipe[RD_LAT-1][3] ? pipe[RD_LAT-1][2:0] : 3'b000;

endmodule

// File: tb/tb_tb_doutb_sched.sv
// Randomized bench for tb_doutb_sched: two instances (read latency 1 and 3)
// are checked every cycle against a timeline model built from the burst rules.
module tb_tb_doutb_sched;
    localparam int unsigned AW   = 10;
    localparam int unsigned LW   = 8;
    localparam int unsigned NCYC = 2500;
    localparam int unsigned HOR  = NCYC + 64;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tb_doutb_sched_if #(.TB_AW(AW), .LEN_W(LW)) bus0 ();
    tb_doutb_sched_if #(.TB_AW(AW), .LEN_W(LW)) bus1 ();

    // stimulus per instance k, requester r (0 = B, 1 = B_cache)
    logic          vld   [2][2];
    logic [AW-1:0] raddr [2][2];
    logic [LW-1:0] rlen  [2][2];
    logic [1:0]    rdir  [2][2];

    logic          o_enb   [2];
    logic [AW-1:0] o_addr  [2];
    logic [2:0]    o_sel   [2];
    logic          o_busy  [2];
    logic          o_brdy  [2];
    logic          o_bcrdy [2];
    logic          o_bdone [2];
    logic          o_bcdone[2];

    assign bus0.b_req_vld   = vld[0][0];
    assign bus0.b_req_addr  = raddr[0][0];
    assign bus0.b_req_len   = rlen[0][0];
    assign bus0.b_req_dir   = rdir[0][0];
    assign bus0.bc_req_vld  = vld[0][1];
    assign bus0.bc_req_addr = raddr[0][1];
    assign bus0.bc_req_len  = rlen[0][1];
    assign bus0.bc_req_dir  = rdir[0][1];
    assign bus1.b_req_vld   = vld[1][0];
    assign bus1.b_req_addr  = raddr[1][0];
    assign bus1.b_req_len   = rlen[1][0];
    assign bus1.b_req_dir   = rdir[1][0];
    assign bus1.bc_req_vld  = vld[1][1];
    assign bus1.bc_req_addr = raddr[1][1];
    assign bus1.bc_req_len  = rlen[1][1];
    assign bus1.bc_req_dir  = rdir[1][1];

    assign o_brdy[0]   = bus0.b_req_rdy;
    assign o_bcrdy[0]  = bus0.bc_req_rdy;
    assign o_bdone[0]  = bus0.b_done;
    assign o_bcdone[0] = bus0.bc_done;
    assign o_brdy[1]   = bus1.b_req_rdy;
    assign o_bcrdy[1]  = bus1.bc_req_rdy;
    assign o_bdone[1]  = bus1.b_done;
    assign o_bcdone[1] = bus1.bc_done;

    tb_doutb_sched #(.TB_AW(AW), .LEN_W(LW), .RD_LAT(1)) u_dut0 (
        .clk          (clk),
        .sys_rst_n    (rst_n),
        .req          (bus0),
        .TB_enb       (o_enb[0]),
        .TB_addrb     (o_addr[0]),
        .TB_doutb_sel (o_sel[0]),
        .busy         (o_busy[0])
    );

    tb_doutb_sched #(.TB_AW(AW), .LEN_W(LW), .RD_LAT(3)) u_dut1 (
        .clk          (clk),
        .sys_rst_n    (rst_n),
        .req          (bus1),
        .TB_enb       (o_enb[1]),
        .TB_addrb     (o_addr[1]),
        .TB_doutb_sel (o_sel[1]),
        .busy         (o_busy[1])
    );

    // expected timeline per instance, indexed by cycle number
    bit          e_enb    [2][HOR];
    logic [AW-1:0] e_addr [2][HOR];
    logic [2:0]  e_sel    [2][HOR];
    bit          e_busy   [2][HOR];
    bit          e_bdone  [2][HOR];
    bit          e_bcdone [2][HOR];
    int          idle_from[2];
    int          last_g   [2];   // 0 none since reset, 1 B, 2 B_cache
    bit          acc_prev [2][2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_req(input int k, input int r, input bit sat);
        vld[k][r]  = 1'b1;
        rlen[k][r] = sat ? LW'(2) : LW'($urandom_range(0, 8));
        if ($urandom_range(0, 1) == 0)
            raddr[k][r] = AW'($urandom);
        else
            raddr[k][r] = AW'(10'h3F8 + 10'($urandom_range(0, 7)));
        rdir[k][r] = 2'($urandom_range(0, 3));
    endtask

    task automatic update_req(input int k, input int r, input bit sat);
        if (sat) begin
            if (!vld[k][r] || acc_prev[k][r]) new_req(k, r, 1'b1);
        end else if (vld[k][r] && acc_prev[k][r]) begin
            if ($urandom_range(0, 2) == 0) new_req(k, r, 1'b0);
            else vld[k][r] = 1'b0;
        end else if (vld[k][r]) begin
            if ($urandom_range(0, 15) == 0) vld[k][r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            new_req(k, r, 1'b0);
        end
    endtask

    task automatic model_and_check(input int k, input int c);
        int lt;
        int w;
        int len;
        bit b_ok;
        bit bc_ok;
        bit x_brdy;
        bit x_bcrdy;
        lt = (k == 0) ? 1 : 3;
        x_brdy  = 1'b0;
        x_bcrdy = 1'b0;
        acc_prev[k][0] = 1'b0;
        acc_prev[k][1] = 1'b0;
        if (!rst_n) begin
            for (int j = c; j < c + 24 && j < int'(HOR); j++) begin
                e_enb[k][j] = 1'b0; e_addr[k][j] = '0; e_sel[k][j] = '0;
                e_busy[k][j] = 1'b0; e_bdone[k][j] = 1'b0; e_bcdone[k][j] = 1'b0;
            end
            idle_from[k] = c + 1;
            last_g[k]    = 0;
        end else if (c >= idle_from[k]) begin
            b_ok  = vld[k][0] && (rlen[k][0] != 0);
            bc_ok = vld[k][1] && (rlen[k][1] != 0);
            w = -1;
`ifdef TB_SCHED_RR_EN
            if (b_ok && bc_ok) w = (last_g[k] == 1) ? 1 : 0;
            else if (b_ok)     w = 0;
            else if (bc_ok)    w = 1;
`else
            if (b_ok)          w = 0;
            else if (bc_ok)    w = 1;
`endif
            if (w >= 0) begin
                if (w == 0) x_brdy = 1'b1; else x_bcrdy = 1'b1;
                len = int'(rlen[k][w]);
                for (int i = 0; i < len; i++) begin
                    e_enb[k][c+1+i]    = 1'b1;
                    e_addr[k][c+1+i]   = raddr[k][w] + AW'(i);
                    e_sel[k][c+1+lt+i] = {w[0], rdir[k][w]};
                end
                for (int i = 1; i <= len + lt; i++) e_busy[k][c+i] = 1'b1;
                if (w == 0) e_bdone[k][c+len+lt]  = 1'b1;
                else        e_bcdone[k][c+len+lt] = 1'b1;
                idle_from[k]   = c + len + lt + 1;
                last_g[k]      = w + 1;
                acc_prev[k][w] = 1'b1;
            end
        end
        check($sformatf("u%0d.TB_enb", k),       32'(o_enb[k]),    32'(e_enb[k][c]));
        if (e_enb[k][c] || !rst_n)
            check($sformatf("u%0d.TB_addrb", k), 32'(o_addr[k]),   32'(e_addr[k][c]));
        check($sformatf("u%0d.TB_doutb_sel", k), 32'(o_sel[k]),    32'(e_sel[k][c]));
        check($sformatf("u%0d.busy", k),         32'(o_busy[k]),   32'(e_busy[k][c]));
        check($sformatf("u%0d.b_done", k),       32'(o_bdone[k]),  32'(e_bdone[k][c]));
        check($sformatf("u%0d.bc_done", k),      32'(o_bcdone[k]), 32'(e_bcdone[k][c]));
        check($sformatf("u%0d.b_req_rdy", k),    32'(o_brdy[k]),   32'(x_brdy));
        check($sformatf("u%0d.bc_req_rdy", k),   32'(o_bcrdy[k]),  32'(x_bcrdy));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_from[k] = 0;
            last_g[k]    = 0;
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = 1'b0; raddr[k][r] = '0; rlen[k][r] = '0; rdir[k][r] = '0;
                acc_prev[k][r] = 1'b0;
            end
        end
        for (int c = 0; c < int'(NCYC); c++) begin
            @(negedge clk);
            cyc = c;
            if (c < 3) rst_n = 1'b0;
            else if (!rst_n) rst_n = 1'b1;
            else if (e_busy[0][c] && $urandom_range(0, 39) == 0) rst_n = 1'b0;
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    update_req(k, r, (c >= 1500 && c < 1800));
                end
            end
            #1;
            for (int k = 0; k < 2; k++) model_and_check(k, c);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
